// File: rtl/core_seq.sv
// Convolution-core sequencer: streams one feature map through the core in raster
// order and writes the valid conv/pool results to consecutive output addresses.
module core_seq #(
    parameter int IMG_W    = 26,
    parameter int IMG_H    = 26,
    parameter int CONV_DLY = 1,
    parameter int POOL_DLY = 2,
    parameter int AW       = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    layer_in,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [1:0]    core_layer,
    output logic [AW-1:0] in_addr,
    output logic          in_ren,
    output logic [1:0]    w_addr,
    input  logic [20:0]   core_o,
    output logic          out_we,
    output logic [AW-1:0] out_addr,
    output logic [20:0]   out_wdata
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int MAXD = (CONV_DLY > POOL_DLY) ? CONV_DLY : POOL_DLY;
    localparam int XW   = $clog2(IMG_W) + 1;
    localparam int YW   = $clog2(IMG_H) + 1;
    localparam int DCW  = $clog2(MAXD + 2) + 1;

    localparam logic [1:0] L_CONV    = 2'd2;
    localparam logic [1:0] L_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      layer_q, layer_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [AW-1:0]   pix_q, pix_d;
    logic            ren_q, ren_d;
    logic [DCW-1:0]  drain_q, drain_d;
    logic [MAXD:0]   tag_q, tag_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            we_q, we_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [20:0]     wdata_q, wdata_d;

    logic            tag_in;
    logic            tap;
    logic [DCW-1:0]  dly;

    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        x_d     = x_q;
        y_d     = y_q;
        pix_d   = pix_q;
        ren_d   = 1'b0;
        drain_d = drain_q;
        err_d   = 1'b0;

        // A pool window completes on its bottom-right pixel: both window-relative
        // coordinates odd, which for a 2-pixel border means x and y odd.
        tag_in = (state_q == S_STREAM) && (x_q >= XW'(2)) && (y_q >= YW'(2)) &&
                 ((layer_q == L_CONV) || (x_q[0] && y_q[0]));
        tag_d  = {tag_q[MAXD-1:0], tag_in};
        tap    = (layer_q == L_CONV) ? tag_q[CONV_DLY] : tag_q[POOL_DLY];
        dly    = (layer_q == L_CONV) ? DCW'(CONV_DLY) : DCW'(POOL_DLY);

        we_d    = tap;
        wdata_d = tap ? core_o : wdata_q;
        waddr_d = we_q ? waddr_q + AW'(1) : waddr_q;

        case (state_q)
            S_IDLE: begin
                if (start && (layer_in == L_ILLEGAL)) begin
                    err_d = 1'b1;
                end else if (start) begin
                    state_d = S_STREAM;
                    layer_d = layer_in;
                    x_d     = '0;
                    y_d     = '0;
                    pix_d   = '0;
                    ren_d   = 1'b1;
                    waddr_d = '0;
                end
            end
            S_STREAM: begin
                if (pix_q == AW'(NPIX - 1)) begin
                    state_d = S_DRAIN;
                    drain_d = '0;
                end else begin
                    ren_d = 1'b1;
                    pix_d = pix_q + AW'(1);
                    if (x_q == XW'(IMG_W - 1)) begin
                        x_d = '0;
                        y_d = y_q + YW'(1);
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end
            end
            S_DRAIN: begin
                // Covers the SRAM read cycle, the core delay and the output register.
                drain_d = drain_q + DCW'(1);
                if (drain_q == dly + DCW'(1)) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            layer_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            pix_q   <= '0;
            ren_q   <= 1'b0;
            drain_q <= '0;
            tag_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            x_q     <= x_d;
            y_q     <= y_d;
            pix_q   <= pix_d;
            ren_q   <= ren_d;
            drain_q <= drain_d;
            tag_q   <= tag_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign core_layer = layer_q;
    assign w_addr     = layer_q;
    assign in_addr    = pix_q;
    assign in_ren     = ren_q;
    assign out_we     = we_q;
    assign out_addr   = waddr_q;
    assign out_wdata  = wdata_q;

endmodule

// File: tb/tb_core_seq.sv
// Directed bench for core_seq with a behavioural input SRAM and core delay model.
module tb_core_seq;

    localparam int IMG_W    = 26;
    localparam int IMG_H    = 26;
    localparam int CONV_DLY = 1;
    localparam int POOL_DLY = 2;
    localparam int AW       = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    layer_in = 2'd0;
    logic          busy, done, err, in_ren, out_we;
    logic [1:0]    core_layer, w_addr;
    logic [AW-1:0] in_addr, out_addr;
    logic [20:0]   core_o, out_wdata;

    core_seq #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .CONV_DLY(CONV_DLY), .POOL_DLY(POOL_DLY), .AW(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .layer_in(layer_in),
        .busy(busy), .done(done), .err(err), .core_layer(core_layer),
        .in_addr(in_addr), .in_ren(in_ren), .w_addr(w_addr), .core_o(core_o),
        .out_we(out_we), .out_addr(out_addr), .out_wdata(out_wdata)
    );

    always #5 clk = ~clk;

    // Input SRAM holds the pixel index; the core emits 7*pixel+1000 after its delay.
    logic [15:0] i_data = 16'd0;
    logic [15:0] sh0 = 16'd0;
    logic [15:0] sh1 = 16'd0;
    always @(posedge clk) begin
        i_data <= in_ren ? 16'(in_addr) : 16'd0;
        sh0    <= i_data;
        sh1    <= sh0;
    end
    always_comb begin
        core_o = 21'(7 * int'((core_layer == 2'd2) ? sh0 : sh1) + 1000);
    end

    int n_pass = 0;
    int n_chk  = 0;
    int exp_k[$];

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic build_expect(input int layer);
        exp_k.delete();
        for (int y = 0; y < IMG_H; y++) begin
            for (int x = 0; x < IMG_W; x++) begin
                int cx, cy;
                cx = x - 2;
                cy = y - 2;
                if (x >= 2 && y >= 2 && (layer == 2 || (cx % 2 == 1 && cy % 2 == 1)))
                    exp_k.push_back(y * IMG_W + x);
            end
        end
    endtask

    // Call just after a rising edge; returns just after the edge following done.
    task automatic run_layer(input int layer, input bit intrude,
                             output int first_cyc, output int last_cyc,
                             output int last_addr, output int done_cyc);
        int d;
        int widx;
        d         = (layer == 2) ? CONV_DLY : POOL_DLY;
        widx      = 0;
        first_cyc = -1;
        last_cyc  = -1;
        last_addr = -1;
        done_cyc  = -1;
        build_expect(layer);
        start    = 1'b1;
        layer_in = 2'(layer);
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            if (cyc == 0) check("busy_idle", int'(busy), 0);
            if (cyc == 1) begin
                check("busy_start", int'(busy), 1);
                check("in_ren_first", int'(in_ren), 1);
                check("in_addr_first", int'(in_addr), 0);
                check("out_addr_clear", int'(out_addr), 0);
                check("w_addr", int'(w_addr), layer);
            end
            if (intrude && cyc == 101) check("err_while_busy", int'(err), 0);
            if (out_we) begin
                check("we_in_busy", int'(busy), 1);
                if (widx < exp_k.size()) begin
                    check("we_cycle", cyc, 3 + exp_k[widx] + d);
                    check("out_addr", int'(out_addr), widx);
                    check("out_wdata", int'(out_wdata), 7 * exp_k[widx] + 1000);
                    check("core_layer", int'(core_layer), layer);
                    if (widx == 0) first_cyc = cyc;
                    last_cyc  = cyc;
                    last_addr = int'(out_addr);
                end else begin
                    check("extra_write", widx, exp_k.size());
                end
                widx++;
            end
            if (done) begin
                done_cyc = cyc;
                check("write_count", widx, exp_k.size());
                check("out_addr_end", int'(out_addr), exp_k.size());
                break;
            end
            @(posedge clk);
            #1;
            start    = intrude && (cyc + 1 == 100);
            layer_in = (intrude && (cyc + 1 == 100)) ? 2'd3 : 2'(layer);
        end
        check("done_seen", int'(done_cyc >= 0), 1);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic check_reset_values(input string sfx);
        check({"rst_busy", sfx}, int'(busy), 0);
        check({"rst_done", sfx}, int'(done), 0);
        check({"rst_err", sfx}, int'(err), 0);
        check({"rst_core_layer", sfx}, int'(core_layer), 0);
        check({"rst_in_addr", sfx}, int'(in_addr), 0);
        check({"rst_in_ren", sfx}, int'(in_ren), 0);
        check({"rst_w_addr", sfx}, int'(w_addr), 0);
        check({"rst_out_we", sfx}, int'(out_we), 0);
        check({"rst_out_addr", sfx}, int'(out_addr), 0);
        check({"rst_out_wdata", sfx}, int'(out_wdata), 0);
    endtask

    initial begin
        int f, l, a, dn;

        @(negedge clk);
        check_reset_values("_init");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_layer(0, 1'b0, f, l, a, dn);
        check("l0_first_we", f, 86);
        check("l0_last_we", l, 680);
        check("l0_last_addr", a, 143);
        check("l0_done", dn, 681);

        run_layer(2, 1'b0, f, l, a, dn);
        check("l2_first_we", f, 58);
        check("l2_last_we", l, 679);
        check("l2_last_addr", a, 575);
        check("l2_done", dn, 680);

        // Back-to-back start, with an illegal start arriving mid-run.
        run_layer(2, 1'b1, f, l, a, dn);
        check("l2i_first_we", f, 58);
        check("l2i_last_we", l, 679);
        check("l2i_last_addr", a, 575);
        check("l2i_done", dn, 680);

        @(negedge clk);
        check("post_busy", int'(busy), 0);
        check("post_done", int'(done), 0);
        @(posedge clk);
        #1;
        start    = 1'b1;
        layer_in = 2'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("err_pulse", int'(err), 1);
        check("err_busy", int'(busy), 0);
        check("err_in_ren", int'(in_ren), 0);
        check("err_layer_kept", int'(core_layer), 2);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("err_one_cycle", int'(err), 0);
        check("err_busy2", int'(busy), 0);
        check("err_in_ren2", int'(in_ren), 0);

        // Asynchronous reset in the middle of a run.
        @(posedge clk);
        #1;
        start    = 1'b1;
        layer_in = 2'd2;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        @(negedge clk);
        check("mid_busy", int'(busy), 1);
        check("mid_out_wdata_live", int'(out_wdata != 21'd0), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_values("_async");
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_layer(1, 1'b0, f, l, a, dn);
        check("l1_first_we", f, 86);
        check("l1_last_we", l, 680);
        check("l1_last_addr", a, 143);
        check("l1_done", dn, 681);
        @(negedge clk);
        check("l1_post_busy", int'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
